// File: rtl/muxsh_pkg.sv
// muxsh_pkg: shared definitions for the muxsh shift register slice.
//   CMD_*   : 2-bit command encoding carried on the cmd bus
//   state_t : control FSM state (idle / multi-cycle shift)
package muxsh_pkg;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_SHL  = 2'b10;
  localparam logic [1:0] CMD_SHR  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/muxsh_shift_reg_if.sv
// muxsh_shift_reg_if: command/data bundle for muxsh_shift_reg.
//   src       : NSRC flattened W-bit load sources, source i at [i*W +: W]
//   src_sel   : load source index
//   cmd_valid : command present
//   cmd       : NOP / LOAD / SHL / SHR
//   amount    : shift count for SHL/SHR
//   sin       : serial fill bit, sampled on every shift edge
//   cmd_ready : command can be accepted
//   q         : register contents
//   sout      : last bit shifted out
//   busy      : multi-cycle shift in progress
//   done      : one-cycle completion pulse
// master drives commands, slave is the shift register.
interface muxsh_shift_reg_if #(
  parameter int W    = 64,
  parameter int NSRC = 2,
  parameter int SELW = $clog2(NSRC),
  parameter int AW   = $clog2(W + 1)
);
  logic [NSRC*W-1:0] src;
  logic [SELW-1:0]   src_sel;
  logic              cmd_valid;
  logic [1:0]        cmd;
  logic [AW-1:0]     amount;
  logic              sin;
  logic              cmd_ready;
  logic [W-1:0]      q;
  logic              sout;
  logic              busy;
  logic              done;

  modport master (
    output src, src_sel, cmd_valid, cmd, amount, sin,
    input  cmd_ready, q, sout, busy, done
  );

  modport slave (
    input  src, src_sel, cmd_valid, cmd, amount, sin,
    output cmd_ready, q, sout, busy, done
  );
endinterface

// File: rtl/muxn_w.sv
// muxn_w: combinational NSRC:1 selector of W-bit buses.
//   in  : flattened sources, source i at [i*W +: W]
//   sel : source index; any value >= NSRC yields all zeros
//   out : selected source
module muxn_w #(
  parameter int W    = 64,
  parameter int NSRC = 2,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic [NSRC*W-1:0] in,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out
);

  logic [NSRC-1:0][W-1:0] srcs;
  assign srcs = in;

  // No match for out-of-range sel leaves the zero default in place.
  always_comb begin
    out = '0;
    for (int i = 0; i < NSRC; i++)
      if (sel == SELW'(i)) out = srcs[i];
  end

endmodule

// File: rtl/muxsh_shift_reg.sv
// muxsh_shift_reg: W-bit register loaded from one of NSRC sources, or
// serially shifted left/right one bit per cycle by a commanded amount.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of muxsh_shift_reg_if (command in, q/sout/
//                busy/done/cmd_ready out)
// cmd_ready and busy decode the state register only; all other outputs
// are registers.
module muxsh_shift_reg
  import muxsh_pkg::*;
#(
  parameter int W    = 64,
  parameter int NSRC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  muxsh_shift_reg_if.slave    bus
);

  localparam int SELW = $clog2(NSRC);
  localparam int AW   = $clog2(W + 1);

  state_t         state;
  logic [AW-1:0]  cnt;
  logic           dir_r;   // 1 = shift right
  logic [W-1:0]   q_r;
  logic           sout_r;
  logic           done_r;
  logic [W-1:0]   ld_val;
  logic [AW-1:0]  amt_c;

  muxn_w #(.W(W), .NSRC(NSRC), .SELW(SELW)) u_mux (
    .in  (bus.src),
    .sel (bus.src_sel),
    .out (ld_val)
  );

  // Shifting more than W just flushes the register with sin history.
  assign amt_c = (bus.amount > AW'(W)) ? AW'(W) : bus.amount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dir_r  <= 1'b0;
      q_r    <= '0;
      sout_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd)
              CMD_LOAD: begin
                q_r    <= ld_val;
                done_r <= 1'b1;
              end
              CMD_SHL, CMD_SHR: begin
                if (amt_c == '0) begin
                  done_r <= 1'b1;
                end else begin
                  state <= ST_SHIFT;
                  cnt   <= amt_c;
                  dir_r <= (bus.cmd == CMD_SHR);
                end
              end
              default: done_r <= 1'b1;
            endcase
          end
        end
        ST_SHIFT: begin
          if (dir_r) begin
            q_r    <= {bus.sin, q_r[W-1:1]};
            sout_r <= q_r[0];
          end else begin
            q_r    <= {q_r[W-2:0], bus.sin};
            sout_r <= q_r[W-1];
          end
          cnt <= cnt - 1'b1;
          // Last shift edge: done appears in the first idle cycle.
          if (cnt == AW'(1)) begin
            state  <= ST_IDLE;
            done_r <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = (state == ST_SHIFT);
  assign bus.q         = q_r;
  assign bus.sout      = sout_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_muxsh_shift_reg.sv
// tb_muxsh_shift_reg: directed + randomized check of muxsh_shift_reg
// (W=8, NSRC=4) against a whole-command reference model, plus a
// W=8, NSRC=3 instance for the out-of-range load select.
module tb_muxsh_shift_reg;
  import muxsh_pkg::*;

  localparam int W    = 8;
  localparam int NSRC = 4;
  localparam int SELW = 2;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  muxsh_shift_reg_if #(.W(W), .NSRC(NSRC)) bus ();
  muxsh_shift_reg #(.W(W), .NSRC(NSRC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  muxsh_shift_reg_if #(.W(W), .NSRC(3)) bus3 ();
  muxsh_shift_reg #(.W(W), .NSRC(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [W-1:0] mq;
  logic         msout;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] srcw(input int i);
    return bus.src[i*W +: W];
  endfunction

  // Issue one command and check it to completion against the model.
  // sinm: 0/1 = constant sin, 2 = random per shift edge.
  // hold: keep cmd_valid high with a LOAD of src[sel] during the shift.
  task automatic do_cmd(input logic [1:0] c, input logic [SELW-1:0] sel,
                        input logic [AW-1:0] amt, input int sinm, input bit hold);
    int           k;
    logic [W-1:0] q0, hshl, hshr;
    logic         s;
    @(negedge clk);
    chk("done_low", bus.done, 0);
    chk("ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.src_sel   = sel;
    bus.amount    = amt;
    k  = (c[1] && amt != 0) ? ((int'(amt) > W) ? W : int'(amt)) : 0;
    q0 = mq;
    if (k == 0) begin
      if (c == CMD_LOAD) mq = srcw(int'(sel));
      @(negedge clk);
      chk("done_pulse", bus.done, 1);
      chk("busy_quiet", bus.busy, 0);
      chk("q_ldnop", bus.q, mq);
      chk("sout_keep", bus.sout, msout);
      bus.cmd_valid = 1'b0;
    end else begin
      hshl = '0;
      hshr = '0;
      for (int i = 0; i < k; i++) begin
        @(negedge clk);
        chk("busy_on", bus.busy, 1);
        chk("ready_off", bus.cmd_ready, 0);
        chk("done_off", bus.done, 0);
        if (hold) bus.cmd = CMD_LOAD;
        else      bus.cmd_valid = 1'b0;
        s = (sinm == 2) ? 1'($urandom % 2) : (sinm == 1);
        bus.sin = s;
        hshl = {hshl[W-2:0], s};
        hshr[W-k+i] = s;
      end
      // first sin ends deepest; bits of q0 beyond k fall off the end
      if (c == CMD_SHL) begin
        mq    = (q0 << k) | hshl;
        msout = q0[W-k];
      end else begin
        mq    = (q0 >> k) | hshr;
        msout = q0[k-1];
      end
      @(negedge clk);
      chk("done_shift", bus.done, 1);
      chk("busy_off", bus.busy, 0);
      chk("q_shift", bus.q, mq);
      chk("sout_shift", bus.sout, msout);
      if (hold) begin
        mq = srcw(int'(sel));
        @(negedge clk);
        chk("q_held_load", bus.q, mq);
        chk("done_held", bus.done, 1);
      end
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_q"}, bus.q, 0);
    chk({tag, "_sout"}, bus.sout, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_ready"}, bus.cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.src = '0; bus.src_sel = '0; bus.cmd_valid = 1'b0;
    bus.cmd = CMD_NOP; bus.amount = '0; bus.sin = 1'b0;
    bus3.src = '0; bus3.src_sel = '0; bus3.cmd_valid = 1'b0;
    bus3.cmd = CMD_NOP; bus3.amount = '0; bus3.sin = 1'b0;
    mq = '0; msout = 1'b0;

    // power-on reset, asserted between edges
    #2 rst_n = 1'b0;
    #1 chk_reset("por");
    @(negedge clk); #2 rst_n = 1'b1;

    // out-of-range select on the 3-source instance
    bus3.src = {8'hC3, 8'h11, 8'h22};
    @(negedge clk);
    bus3.cmd_valid = 1'b1; bus3.cmd = CMD_LOAD; bus3.src_sel = 2'd2;
    @(negedge clk);
    chk("n3_load2", bus3.q, 8'hC3);
    bus3.src_sel = 2'd3;
    @(negedge clk);
    chk("n3_oor_q", bus3.q, 8'h00);
    chk("n3_oor_done", bus3.done, 1);
    bus3.cmd_valid = 1'b0;

    // LOAD src3, then SHL 3 with sin=1
    bus.src = {8'hA5, 8'h5A, 8'hFF, 8'h3C};
    do_cmd(CMD_LOAD, 2'd3, 4'd0, 0, 1'b0);
    do_cmd(CMD_SHL, 2'd0, 4'd3, 1, 1'b0);
    chk("shl_q_2F", bus.q, 8'h2F);
    chk("shl_sout_1", bus.sout, 1);

    // SHR by 15 clamps to 8 with a LOAD held pending behind it
    do_cmd(CMD_LOAD, 2'd1, 4'd0, 0, 1'b0);
    do_cmd(CMD_SHR, 2'd2, 4'd15, 0, 1'b1);

    // zero-amount shift acts as NOP
    do_cmd(CMD_SHR, 2'd0, 4'd0, 2, 1'b0);
    do_cmd(CMD_NOP, 2'd1, 4'd5, 2, 1'b0);

    // async reset in the second busy cycle of an 8-bit shift
    do_cmd(CMD_LOAD, 2'd3, 4'd0, 0, 1'b0);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd = CMD_SHR; bus.amount = 4'd8;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("mid_busy1", bus.busy, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid");
    #1 rst_n = 1'b1;
    mq = '0; msout = 1'b0;
    do_cmd(CMD_LOAD, 2'd0, 4'd0, 0, 1'b0);
    chk("post_rst_q", bus.q, 8'h3C);

    // randomized commands
    for (int n = 0; n < 60; n++) begin
      bus.src = $urandom;
      do_cmd(2'($urandom % 4), 2'($urandom % 4), 4'($urandom % 16), 2,
             ($urandom % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
